fpm_round_pack: RTL and testbench



---
 rtl/fpm_pkg.sv | 25 ++
 rtl/fpm_round_nearest.sv | 26 ++
 rtl/fpm_round_pack.sv | 115 +++++++++++
 tb/tb_fpm_round_pack.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpm_pkg.sv
// Shared types and constants for the binary16 multiplier post-processing path.
// FPM_ROUND_NEAREST_EN adds the guard/sticky bits to the stage-1 record.
package fpm_pkg;

    localparam int EXP_BIAS = 15;
    localparam int EXP_W    = 5;
    localparam int FRAC_W   = 10;
    localparam int E_W      = EXP_W + 2;

    // Wide enough for exp_a + exp_b - bias + shift + rounding carry without wrap
    typedef logic signed [E_W-1:0] exp_t;

    typedef struct packed {
        logic              valid;
        logic              sign;
        logic              zero;
        logic [FRAC_W-1:0] frac;
`ifdef FPM_ROUND_NEAREST_EN
        logic              g;
        logic              s;
`endif
        exp_t              e;
    } stage1_t;

endpackage

// File: rtl/fpm_round_nearest.sv
// Round-to-nearest-even increment of the normalised fraction.
// Without FPM_ROUND_NEAREST_EN this is a pass-through (truncation).
module fpm_round_nearest
    import fpm_pkg::*;
(
    input  logic [FRAC_W-1:0] frac,
`ifdef FPM_ROUND_NEAREST_EN
    input  logic              g,
    input  logic              s,
`endif
    output logic [FRAC_W-1:0] frac_r,
    output logic              carry
);

`ifdef FPM_ROUND_NEAREST_EN
    logic inc;

    assign inc = g & (s | frac[0]);
    // A carry out leaves frac_r at zero, which is the correct 1.0 x 2^(e+1) mantissa
    assign {carry, frac_r} = {1'b0, frac} + {{FRAC_W{1'b0}}, inc};
`else
    assign frac_r = frac;
    assign carry  = 1'b0;
`endif

endmodule

// File: rtl/fpm_round_pack.sv
// Two-stage normalise / round-and-pack pipeline for the binary16 multiplier.
// Rounding mode selected by FPM_ROUND_NEAREST_EN (undefined: truncation).
module fpm_round_pack
    import fpm_pkg::*;
#(
    parameter int EXP_BIAS = fpm_pkg::EXP_BIAS,
    parameter int EXP_W    = fpm_pkg::EXP_W,
    parameter int FRAC_W   = fpm_pkg::FRAC_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2*(FRAC_W+1)-1:0]   prod,
    input  logic                      sign_a,
    input  logic                      sign_b,
    input  logic [EXP_W-1:0]          exp_a,
    input  logic [EXP_W-1:0]          exp_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     result,
    output logic                      ovf,
    output logic                      unf
);

    localparam int   PROD_W = 2 * (FRAC_W + 1);
    localparam exp_t E_MAX  = exp_t'((1 << EXP_W) - 1);

    stage1_t               s1_d, s1_q;
    logic                  adv;
    logic [FRAC_W-1:0]     frac_r;
    logic                  carry;
    exp_t                  e2;
    logic [EXP_W+FRAC_W:0] res_d;
    logic                  ovf_d, unf_d;

    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    always_comb begin
        s1_d       = '0;
        s1_d.valid = in_valid;
        s1_d.sign  = sign_a ^ sign_b;
        s1_d.zero  = (exp_a == '0) | (exp_b == '0);
        if (prod[PROD_W-1]) begin
            s1_d.frac = prod[PROD_W-2 -: FRAC_W];
`ifdef FPM_ROUND_NEAREST_EN
            s1_d.g    = prod[FRAC_W];
            s1_d.s    = |prod[FRAC_W-1:0];
`endif
        end else begin
            s1_d.frac = prod[PROD_W-3 -: FRAC_W];
`ifdef FPM_ROUND_NEAREST_EN
            s1_d.g    = prod[FRAC_W-1];
            s1_d.s    = |prod[FRAC_W-2:0];
`endif
        end
        s1_d.e = exp_t'({2'b00, exp_a}) + exp_t'({2'b00, exp_b}) - exp_t'(EXP_BIAS)
               + exp_t'({{(E_W-1){1'b0}}, prod[PROD_W-1]});
    end

`ifndef FPM_ROUND_NEAREST_EN
    logic unused_prod;
    assign unused_prod = ^prod[FRAC_W:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
        end else if (adv) begin
            s1_q <= s1_d;
        end
    end

    fpm_round_nearest u_round (
        .frac   (s1_q.frac),
`ifdef FPM_ROUND_NEAREST_EN
        .g      (s1_q.g),
        .s      (s1_q.s),
`endif
        .frac_r (frac_r),
        .carry  (carry)
    );

    always_comb begin
        e2    = s1_q.e + exp_t'({{(E_W-1){1'b0}}, carry});
        res_d = {s1_q.sign, e2[EXP_W-1:0], frac_r};
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (s1_q.zero) begin
            res_d = {s1_q.sign, {(EXP_W+FRAC_W){1'b0}}};
        end else if (e2 >= E_MAX) begin
            res_d = {s1_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            ovf_d = 1'b1;
        end else if (e2 <= exp_t'(0)) begin
            res_d = {s1_q.sign, {(EXP_W+FRAC_W){1'b0}}};
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_q.valid;
            result    <= res_d;
            ovf       <= ovf_d;
            unf       <= unf_d;
        end
    end

endmodule

// File: tb/tb_fpm_round_pack.sv
// Directed bench for fpm_round_pack; expected values are hand-derived binary16 encodings.
// Rounding expectations follow FPM_ROUND_NEAREST_EN when it is defined for the build.
module tb_fpm_round_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [21:0] prod;
    logic        sign_a, sign_b;
    logic [4:0]  exp_a, exp_b;
    logic        out_valid, out_ready;
    logic [15:0] result;
    logic        ovf, unf;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fpm_round_pack #(
        .EXP_BIAS (15),
        .EXP_W    (5),
        .FRAC_W   (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .exp_a     (exp_a),
        .exp_b     (exp_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .unf       (unf)
    );

    // Single transfer into an empty pipeline; lat counts cycles from accept to out_valid (0 = timeout)
    task automatic do_xfer(input logic [21:0] p, input logic sa, input logic sb,
                           input logic [4:0] ea, input logic [4:0] eb,
                           output logic [15:0] r, output logic o, output logic u, output int lat);
        r = '0; o = 1'b0; u = 1'b0; lat = 0;
        @(negedge clk);
        prod = p; sign_a = sa; sign_b = sb; exp_a = ea; exp_b = eb;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                lat = i; r = result; o = ovf; u = unf;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        prod = '0; sign_a = 1'b0; sign_b = 1'b0; exp_a = '0; exp_b = '0;
        repeat (2) @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        tests++; if (result !== 16'h0000) begin fails++; $display("FAIL reset_result got %h exp 0000", result); end
        tests++; if ({ovf, unf} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b exp 00", {ovf, unf}); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL post_reset_out_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_basic;
        logic [15:0] r; logic o, u; int lat;
        do_xfer(22'h100000, 1'b0, 1'b0, 5'd15, 5'd15, r, o, u, lat);
        tests++; if (r !== 16'h3C00) begin fails++; $display("FAIL one_x_one result got %h exp 3c00", r); end
        tests++; if ({o, u} !== 2'b00) begin fails++; $display("FAIL one_x_one flags got %b exp 00", {o, u}); end
        tests++; if (lat !== 2) begin fails++; $display("FAIL one_x_one latency got %0d exp 2", lat); end
        do_xfer(22'h240000, 1'b0, 1'b1, 5'd15, 5'd15, r, o, u, lat);
        tests++; if (r !== 16'hC080) begin fails++; $display("FAIL m1p5_x_p1p5 result got %h exp c080", r); end
        tests++; if ({o, u} !== 2'b00) begin fails++; $display("FAIL m1p5_x_p1p5 flags got %b exp 00", {o, u}); end
    endtask

    task automatic test_rounding;
        logic [21:0] pv [6] = '{22'h180600, 22'h180400, 22'h180300, 22'h180200, 22'h200C00, 22'h1FFE00};
`ifdef FPM_ROUND_NEAREST_EN
        logic [15:0] ev [6] = '{16'h3E02, 16'h3E01, 16'h3E01, 16'h3E00, 16'h4002, 16'h4000};
`else
        logic [15:0] ev [6] = '{16'h3E01, 16'h3E01, 16'h3E00, 16'h3E00, 16'h4001, 16'h3FFF};
`endif
        logic [15:0] r; logic o, u; int lat;
        for (int i = 0; i < 6; i++) begin
            do_xfer(pv[i], 1'b0, 1'b0, 5'd15, 5'd15, r, o, u, lat);
            tests++; if (r !== ev[i]) begin fails++; $display("FAIL round_%0d result got %h exp %h", i, r, ev[i]); end
            tests++; if ({o, u} !== 2'b00) begin fails++; $display("FAIL round_%0d flags got %b exp 00", i, {o, u}); end
        end
    endtask

    task automatic test_exceptions;
        logic [4:0]  ea [12] = '{5'd30, 5'd1, 5'd0, 5'd30, 5'd30, 5'd1, 5'd1, 5'd15, 5'd31, 5'd15, 5'd0, 5'd30};
        logic [4:0]  eb [12] = '{5'd30, 5'd1, 5'd15, 5'd15, 5'd16, 5'd15, 5'd14, 5'd0, 5'd31, 5'd30, 5'd0, 5'd15};
        logic [21:0] pv [12] = '{22'h100000, 22'h100000, 22'h100000, 22'h100000, 22'h100000, 22'h100000,
                                 22'h100000, 22'h100000, 22'h100000, 22'h200000, 22'h000000, 22'h1FFE00};
        logic        sa [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef FPM_ROUND_NEAREST_EN
        logic [15:0] ev [12] = '{16'h7C00, 16'h0000, 16'h0000, 16'h7800, 16'hFC00, 16'h0400,
                                 16'h8000, 16'h8000, 16'h7C00, 16'h7C00, 16'h0000, 16'h7C00};
        logic [1:0]  fv [12] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00,
                                 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10};
`else
        logic [15:0] ev [12] = '{16'h7C00, 16'h0000, 16'h0000, 16'h7800, 16'hFC00, 16'h0400,
                                 16'h8000, 16'h8000, 16'h7C00, 16'h7C00, 16'h0000, 16'h7BFF};
        logic [1:0]  fv [12] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00,
                                 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
`endif
        logic [15:0] r; logic o, u; int lat;
        for (int i = 0; i < 12; i++) begin
            do_xfer(pv[i], sa[i], 1'b0, ea[i], eb[i], r, o, u, lat);
            tests++; if (r !== ev[i]) begin fails++; $display("FAIL exc_%0d result got %h exp %h", i, r, ev[i]); end
            tests++; if ({o, u} !== fv[i]) begin fails++; $display("FAIL exc_%0d ovf_unf got %b exp %b", i, {o, u}, fv[i]); end
        end
    endtask

    task automatic test_back_to_back;
        int k = 0, r = 0, first = -1, last = -1;
        for (int cyc = 0; cyc < 20 && r < 5; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (k < 5);
            prod = 22'h100000; sign_a = 1'b0; sign_b = 1'b0; exp_a = 5'(15 + k); exp_b = 5'd15;
            #1;
            if (in_valid && in_ready) k++;
            if (out_valid) begin
                tests++;
                if (result !== 16'(16'h3C00 + r * 16'h0400)) begin
                    fails++; $display("FAIL b2b_%0d result got %h exp %h", r, result, 16'(16'h3C00 + r * 16'h0400));
                end
                if (first < 0) first = cyc;
                last = cyc;
                r++;
            end
        end
        in_valid = 1'b0;
        tests++; if (r !== 5) begin fails++; $display("FAIL b2b_count got %0d exp 5", r); end
        tests++; if (first !== 2) begin fails++; $display("FAIL b2b_first_cycle got %0d exp 2", first); end
        tests++; if (last - first !== 4) begin fails++; $display("FAIL b2b_span got %0d exp 4", last - first); end
    endtask

    task automatic test_backpressure;
        logic [4:0]  eav [4] = '{5'd15, 5'd16, 5'd17, 5'd15};
        logic [21:0] pv  [4] = '{22'h100000, 22'h100000, 22'h100000, 22'h240000};
        logic [15:0] ev  [4] = '{16'h3C00, 16'h4000, 16'h4400, 16'h4080};
        int k = 0, r = 0;
        for (int cyc = 0; cyc < 30 && r < 4; cyc++) begin
            @(negedge clk);
            out_ready = (cyc == 0) || (cyc >= 6);
            in_valid  = (k < 4);
            if (k < 4) begin
                prod = pv[k]; sign_a = 1'b0; sign_b = 1'b0; exp_a = eav[k]; exp_b = 5'd15;
            end
            #1;
            if (cyc >= 2 && cyc <= 5) begin
                tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_c%0d got %b exp 0", cyc, in_ready); end
                tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid_c%0d got %b exp 1", cyc, out_valid); end
                tests++; if (result !== 16'h3C00) begin fails++; $display("FAIL bp_hold_c%0d got %h exp 3c00", cyc, result); end
            end
            if (cyc == 6) begin
                tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready got %b exp 1", in_ready); end
            end
            if (in_valid && in_ready) k++;
            if (out_valid && out_ready) begin
                tests++; if (result !== ev[r]) begin fails++; $display("FAIL bp_order_%0d got %h exp %h", r, result, ev[r]); end
                r++;
            end
        end
        in_valid = 1'b0;
        tests++; if (r !== 4) begin fails++; $display("FAIL bp_count got %0d exp 4", r); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_no_dup_%0d got %b exp 0", i, out_valid); end
        end
    endtask

    task automatic test_reset_midflight;
        logic [15:0] r; logic o, u; int lat;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        prod = 22'h100000; sign_a = 1'b0; sign_b = 1'b0; exp_a = 5'd15; exp_b = 5'd15;
        @(negedge clk);
        exp_a = 5'd16;
        @(negedge clk);
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_pre_valid got %b exp 1", out_valid); end
        rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
        tests++; if (result !== 16'h0000) begin fails++; $display("FAIL mid_rst_result got %h exp 0000", result); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_stale_%0d got %b exp 0", i, out_valid); end
        end
        do_xfer(22'h100000, 1'b0, 1'b0, 5'd17, 5'd15, r, o, u, lat);
        tests++; if (r !== 16'h4400) begin fails++; $display("FAIL mid_after result got %h exp 4400", r); end
        tests++; if (lat !== 2) begin fails++; $display("FAIL mid_after latency got %0d exp 2", lat); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_rounding;
        test_exceptions;
        test_back_to_back;
        test_backpressure;
        test_reset_midflight;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
